mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, with at most one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN: alternate between simultaneous requesters instead of fixed LSU priority.
module mem_port_arbiter #(
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its fields until the cycle its gnt is high;
  // the memory side accepts mem_req_o in any cycle mem_gnt_i is high, and a response
  // (rvalid) is a single-cycle pulse that is only meaningful while in S_WAIT.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(RESP_TIMEOUT);

  state_t      state;
  logic        owner_lsu;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wait_cnt;

  logic        any_req;
  logic        capture;
  logic        pick_lsu;
  logic        in_issue;
  logic        in_wait;
  logic        timeout_hit;
  logic        gnt_fire;
  logic        rsp_fire;
  logic        rsp_err;
  logic [31:0] rsp_data;

  assign any_req = if_req_i | lsu_req_i;
  assign capture = (state == S_IDLE) & any_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_lsu;

  // Pointer names the requester that wins the next tie; it moves off every winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_lsu <= 1'b1;
    end else if (capture) begin
      rr_lsu <= ~pick_lsu;
    end
  end

  assign pick_lsu = lsu_req_i & (~if_req_i | rr_lsu);
`else
  assign pick_lsu = lsu_req_i;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      owner_lsu <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_lsu <= pick_lsu;
            we_q      <= pick_lsu & lsu_we_i;
            addr_q    <= pick_lsu ? lsu_addr_i : if_addr_i;
            wdata_q   <= pick_lsu ? lsu_wdata_i : 32'h0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_gnt_i) begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i || timeout_hit) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_issue    = (state == S_ISSUE);
  assign in_wait     = (state == S_WAIT);
  assign timeout_hit = (wait_cnt == TIMEOUT_CNT);

  assign mem_req_o   = in_issue;
  assign mem_we_o    = in_issue & we_q;
  assign mem_addr_o  = in_issue ? addr_q : 32'h0;
  assign mem_wdata_o = in_issue ? wdata_q : 32'h0;

  // A real response in the timeout cycle takes precedence over the error.
  assign gnt_fire = in_issue & mem_gnt_i;
  assign rsp_fire = in_wait & (mem_rvalid_i | timeout_hit);
  assign rsp_err  = in_wait & ~mem_rvalid_i & timeout_hit;
  assign rsp_data = (in_wait & mem_rvalid_i) ? mem_rdata_i : 32'h0;

  assign if_gnt_o     = gnt_fire & ~owner_lsu;
  assign if_rvalid_o  = rsp_fire & ~owner_lsu;
  assign if_err_o     = rsp_err & ~owner_lsu;
  assign if_rdata_o   = owner_lsu ? 32'h0 : rsp_data;

  assign lsu_gnt_o    = gnt_fire & owner_lsu;
  assign lsu_rvalid_o = rsp_fire & owner_lsu;
  assign lsu_err_o    = rsp_err & owner_lsu;
  assign lsu_rdata_o  = owner_lsu ? rsp_data : 32'h0;

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester driver tasks, a behavioural memory and a response scoreboard.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating arbitration order.
module tb_mem_port_arbiter;

  localparam int RESP_TIMEOUT = 16;
  localparam int W = 34;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.RESP_TIMEOUT(RESP_TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .if_err_o     (if_err_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state    (dbg_state)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // checking
  int unsigned checks_total  = 0;
  int unsigned checks_passed = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // memory model
  int unsigned gnt_delay = 0;
  int unsigned rsp_delay = 0;
  bit          drop_rsp  = 1'b0;
  int unsigned stray_req = 0;
  int unsigned stray_ack = 0;
  bit          rsp_pending = 1'b0;
  int unsigned rsp_cnt  = 0;
  int unsigned gnt_wait = 0;
  logic [31:0] rsp_data = 32'h0;

  function automatic logic [31:0] mem_fn(input logic we, input logic [31:0] addr);
    if (we) return 32'h0;
    if (addr == 32'h0000_0100) return 32'hDEAD_BEEF;
    return addr ^ 32'h5A5A_0F0F;
  endfunction

  always begin
    @(posedge clock);
    #1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (rsp_pending) begin
      if (rsp_cnt == 0) begin
        rsp_pending = 1'b0;
        if (!drop_rsp) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rsp_data;
        end
      end else begin
        rsp_cnt--;
      end
    end
    if (stray_req != stray_ack) begin
      stray_ack    = stray_req;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_0BAD;
    end
    if (mem_req_o) begin
      if (gnt_wait == gnt_delay) begin
        mem_gnt_i   = 1'b1;
        gnt_wait    = 0;
        rsp_pending = 1'b1;
        rsp_cnt     = rsp_delay;
        rsp_data    = mem_fn(mem_we_o, mem_addr_o);
      end else begin
        gnt_wait++;
      end
    end else begin
      gnt_wait = 0;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  bit           grant_log[$];
  int unsigned  rsp_seen     = 0;
  int unsigned  last_gnt_cyc = 0;
  int unsigned  last_rsp_cyc = 0;
  int unsigned  lsu_req_cyc  = 0;
  int unsigned  if_req_cyc   = 0;
  logic         prev_req     = 1'b0;
  logic         prev_we      = 1'b0;
  logic [31:0]  prev_addr    = 32'h0;
  logic [31:0]  prev_wdata   = 32'h0;
  logic [W-1:0] obs;

  always @(negedge clock) begin
    if (mem_req_o) begin
      if (prev_req) begin
        check("mem_hold_addr", W'(mem_addr_o), W'(prev_addr));
        check("mem_hold_wdata", W'(mem_wdata_o), W'(prev_wdata));
        check("mem_hold_we", W'(mem_we_o), W'(prev_we));
      end
    end else begin
      check("mem_idle_fields", {mem_we_o, |mem_wdata_o, mem_addr_o}, '0);
    end
    prev_req   = mem_req_o;
    prev_we    = mem_we_o;
    prev_addr  = mem_addr_o;
    prev_wdata = mem_wdata_o;

    if (!if_rvalid_o)  check("if_rsp_idle", {1'b0, if_err_o, if_rdata_o}, '0);
    if (!lsu_rvalid_o) check("lsu_rsp_idle", {1'b0, lsu_err_o, lsu_rdata_o}, '0);

    if (if_gnt_o && lsu_gnt_o) check("dual_gnt", 1, 0);
    else if (lsu_gnt_o) begin
      check("lsu_gnt_req", W'(lsu_req_i), 1);
      check("lsu_issue_addr", W'(mem_addr_o), W'(lsu_addr_i));
      check("lsu_issue_we", W'(mem_we_o), W'(lsu_we_i));
      check("lsu_issue_wdata", W'(mem_wdata_o), W'(lsu_wdata_i));
      exp_q.push_back(drop_rsp ? {1'b1, 1'b1, 32'h0} : {1'b1, 1'b0, mem_fn(lsu_we_i, lsu_addr_i)});
      grant_log.push_back(1'b1);
      last_gnt_cyc = cyc;
    end else if (if_gnt_o) begin
      check("if_gnt_req", W'(if_req_i), 1);
      check("if_issue_addr", W'(mem_addr_o), W'(if_addr_i));
      check("if_issue_we_wdata", {mem_we_o, 1'b0, mem_wdata_o}, '0);
      exp_q.push_back(drop_rsp ? {1'b0, 1'b1, 32'h0} : {1'b0, 1'b0, mem_fn(1'b0, if_addr_i)});
      grant_log.push_back(1'b0);
      last_gnt_cyc = cyc;
    end

    if (if_rvalid_o && lsu_rvalid_o) check("dual_rvalid", 1, 0);
    else if (if_rvalid_o || lsu_rvalid_o) begin
      rsp_seen++;
      last_rsp_cyc = cyc;
      obs = lsu_rvalid_o ? {1'b1, lsu_err_o, lsu_rdata_o} : {1'b0, if_err_o, if_rdata_o};
      if (exp_q.size() == 0) check("unexpected_rvalid", 1, 0);
      else check("rsp", obs, exp_q.pop_front());
    end
  end

  // driver tasks (called at posedge + 1)
  task automatic lsu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    bit done = 1'b0;
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    lsu_req_cyc = cyc;
    while (!done && n < 200) begin
      @(negedge clock);
      if (lsu_gnt_o) done = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    lsu_req_i   = 1'b0;
    lsu_we_i    = 1'b0;
    lsu_addr_i  = 32'h0;
    lsu_wdata_i = 32'h0;
    if (!done) check("lsu_gnt_wait", 0, 1);
  endtask

  task automatic fetch_access(input logic [31:0] addr);
    int n = 0;
    bit done = 1'b0;
    if_req_i   = 1'b1;
    if_addr_i  = addr;
    if_req_cyc = cyc;
    while (!done && n < 200) begin
      @(negedge clock);
      if (if_gnt_o) done = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    if_req_i  = 1'b0;
    if_addr_i = 32'h0;
    if (!done) check("if_gnt_wait", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain", W'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o,
                mem_req_o, mem_we_o, |if_rdata_o, |lsu_rdata_o, |mem_addr_o, |mem_wdata_o}, '0);
    check({tag, "_state"}, W'(dbg_state), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [31:0] rnd_addr;
  bit          exp_owner;
  int unsigned seen_before;

  initial begin
    reset = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_outputs");
    @(posedge clock);
    #1;

    // minimum-latency load
    lsu_access(1'b0, 32'h0000_0100, 32'h0);
    wait_drain();
    check("load_gnt_latency", W'(last_gnt_cyc - lsu_req_cyc), 1);
    check("load_rsp_latency", W'(last_rsp_cyc - lsu_req_cyc), 2);

    // store: issue fields checked by the monitor at grant
    lsu_access(1'b1, 32'h0000_0200, 32'h1234_5678);
    wait_drain();

    // grant held off three cycles, stray rvalid while in ISSUE
    gnt_delay = 3;
    fork
      fetch_access(32'h0000_0400);
      begin
        repeat (2) @(posedge clock);
        stray_req++;
      end
    join
    wait_drain();
    check("held_gnt_latency", W'(last_gnt_cyc - if_req_cyc), 4);
    gnt_delay = 0;

    // mixed traffic with random memory timing
    for (int i = 0; i < 8; i++) begin
      gnt_delay = $urandom_range(0, 2);
      rsp_delay = $urandom_range(0, 3);
      rnd_addr = $urandom;
      rnd_addr[1:0] = 2'b00;
      if (i % 2 == 1) lsu_access(1'($urandom_range(0, 1)), rnd_addr, $urandom);
      else fetch_access(rnd_addr);
      wait_drain();
    end
    gnt_delay = 0;
    rsp_delay = 0;

    // response timeout, then a stray rvalid in IDLE
    drop_rsp = 1'b1;
    lsu_access(1'b0, 32'h0000_0300, 32'h0);
    wait_drain();
    check("timeout_latency", W'(last_rsp_cyc - last_gnt_cyc), W'(RESP_TIMEOUT + 1));
    drop_rsp = 1'b0;
    seen_before = rsp_seen;
    stray_req++;
    repeat (3) @(posedge clock);
    #1;
    check("stray_idle_ignored", W'(rsp_seen), W'(seen_before));

    // reset while in WAIT abandons the transaction
    rsp_delay = 4;
    lsu_access(1'b0, 32'h0000_0500, 32'h0);
    check("wait_before_reset", W'(dbg_state), 2);
    pulse_reset();
    exp_q.delete();
    seen_before = rsp_seen;
    @(negedge clock);
    check_all_zero("reset_in_wait");
    repeat (8) @(posedge clock);
    #1;
    check("abandoned_rsp_ignored", W'(rsp_seen), W'(seen_before));
    rsp_delay = 0;
    lsu_access(1'b0, 32'h0000_0600, 32'h0);
    wait_drain();
    check("after_reset_latency", W'(last_rsp_cyc - lsu_req_cyc), 2);

    // both requesters continuously busy
    pulse_reset();
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) lsu_access(1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0);
      for (int j = 0; j < 4; j++) fetch_access(32'h0000_2000 + 32'(j * 4));
    join
    wait_drain();
    check("arb_grant_count", W'(grant_log.size()), 8);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_owner = (k % 2 == 0);
`else
      exp_owner = 1'b1;
`endif
      check($sformatf("arb_order_%0d", k), W'(grant_log[k]), W'(exp_owner));
    end

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
